voice_scheduler: RTL and testbench

Allocates incoming notes from the song reader to a pool of `note_player` voices for polyphonic playback. It holds one pending note and picks a free voice round-robin. It issues a one-cycle load strobe with note and duration to that voice, and reports how many voices are sounding so the sample mixer can scale its sum. It sits between the song reader and the voice bank, replacing ad-hoc first-free priority loading.

---
 rtl/voice_sched_pkg.sv | 15 +
 rtl/rr_free_picker.sv | 29 ++
 rtl/voice_scheduler.sv | 176 +++++++++++++++++
 tb/tb_voice_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sched_pkg.sv
// Shared types and constants for the voice scheduler: FSM encoding, default
// note/duration widths and the duration code that marks a rest.
package voice_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int unsigned NOTE_W        = 6;
    localparam int unsigned DUR_W         = 6;
    localparam int unsigned REST_DURATION = 0;

endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin picker: grants the first free voice at or after
// i_rr_ptr, wrapping around, and flags whether any voice is free.
module rr_free_picker #(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic [NUM_VOICES-1:0]         i_free,
    input  logic [$clog2(NUM_VOICES)-1:0] i_rr_ptr,
    output logic [NUM_VOICES-1:0]         o_grant,
    output logic                          o_any_free
);

    int unsigned w_best;

    // Smallest forward distance from the pointer wins; avoids a variable index.
    always_comb begin
        o_grant = '0;
        w_best  = NUM_VOICES;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (i_free[i] && (((i + NUM_VOICES - 32'(i_rr_ptr)) % NUM_VOICES) < w_best)) begin
                w_best     = (i + NUM_VOICES - 32'(i_rr_ptr)) % NUM_VOICES;
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

    assign o_any_free = |i_free;

endmodule

// File: rtl/voice_scheduler.sv
// Holds one pending note and loads it into a free note_player voice, round-robin.
// Define VOICE_STEAL_EN to steal the oldest busy voice instead of waiting.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned NOTE_W     = voice_sched_pkg::NOTE_W,
    parameter int unsigned DUR_W      = voice_sched_pkg::DUR_W,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic                            beat,
    input  logic [NOTE_W-1:0]               note_in,
    input  logic [DUR_W-1:0]                duration_in,
    input  logic                            note_valid,
    output logic                            note_ready,
    input  logic [NUM_VOICES-1:0]           voice_done,
    output logic [NUM_VOICES-1:0]           load_voice,
    output logic [NOTE_W-1:0]               load_note,
    output logic [DUR_W-1:0]                load_duration,
    output logic [NUM_VOICES-1:0]           active_mask,
    output logic [$clog2(NUM_VOICES+1)-1:0] active_count
);
    import voice_sched_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W = $clog2(NUM_VOICES + 1);

    if (NUM_VOICES < 2 || NUM_VOICES > 8 || AGE_W < 1) begin : g_param_check
        $error("voice_scheduler: NUM_VOICES must be 2..8 and AGE_W at least 1");
    end

    state_t                r_state;
    logic [NOTE_W-1:0]     r_pend_note;
    logic [DUR_W-1:0]      r_pend_dur;
    logic [NUM_VOICES-1:0] r_load_voice;
    logic [NOTE_W-1:0]     r_load_note;
    logic [DUR_W-1:0]      r_load_dur;
    logic [NUM_VOICES-1:0] r_reserved;
    logic [PTR_W-1:0]      r_rr_ptr;

    logic [NUM_VOICES-1:0] w_free;
    logic [NUM_VOICES-1:0] w_active;
    logic [NUM_VOICES-1:0] w_rr_grant;
    logic [NUM_VOICES-1:0] w_sel;
    logic                  w_any_free;
    logic                  w_is_rest;
    logic                  w_take;
    logic [PTR_W-1:0]      w_next_ptr;
    logic [CNT_W-1:0]      w_count;

    assign w_free        = voice_done & ~r_reserved;
    assign w_active      = ~voice_done | r_reserved;
    assign w_is_rest     = (r_pend_dur == DUR_W'(REST_DURATION));
    assign note_ready    = (r_state == IDLE);
    assign load_voice    = r_load_voice;
    assign load_note     = r_load_note;
    assign load_duration = r_load_dur;
    assign active_mask   = w_active;
    assign active_count  = w_count;

    rr_free_picker #(
        .NUM_VOICES (NUM_VOICES)
    ) u_picker (
        .i_free     (w_free),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_rr_grant),
        .o_any_free (w_any_free)
    );

    always_comb begin
        w_next_ptr = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (w_rr_grant[i]) begin
                w_next_ptr = PTR_W'((i + 1) % NUM_VOICES);
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            w_count = w_count + CNT_W'(w_active[i]);
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]      r_age [NUM_VOICES];
    logic [AGE_W-1:0]      w_best_age;
    logic [NUM_VOICES-1:0] w_steal;

    // Strict greater-than keeps ties on the lowest index.
    always_comb begin
        w_steal    = NUM_VOICES'(1);
        w_best_age = r_age[0];
        for (int unsigned i = 1; i < NUM_VOICES; i++) begin
            if (r_age[i] > w_best_age) begin
                w_best_age = r_age[i];
                w_steal    = '0;
                w_steal[i] = 1'b1;
            end
        end
    end

    assign w_sel  = w_any_free ? w_rr_grant : w_steal;
    assign w_take = (r_state == HOLD) && play && !w_is_rest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (w_take && w_sel[i]) begin
                    r_age[i] <= '0;
                end else if (beat && play && w_active[i] && (r_age[i] != '1)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end
`else
    logic w_beat_unused;

    assign w_beat_unused = beat;
    assign w_sel         = w_rr_grant;
    assign w_take        = (r_state == HOLD) && play && !w_is_rest && w_any_free;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pend_note  <= '0;
            r_pend_dur   <= '0;
            r_load_voice <= '0;
            r_load_note  <= '0;
            r_load_dur   <= '0;
            r_reserved   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            // A reservation drops on the first cycle its player reports busy.
            r_reserved <= (r_reserved & voice_done) | (w_take ? w_sel : '0);
            case (r_state)
                IDLE: begin
                    if (note_valid) begin
                        r_pend_note <= note_in;
                        r_pend_dur  <= duration_in;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (play && w_is_rest) begin
                        r_state <= IDLE;
                    end else if (w_take) begin
                        r_load_voice <= w_sel;
                        r_load_note  <= r_pend_note;
                        r_load_dur   <= r_pend_dur;
                        r_state      <= ISSUE;
                        if (w_any_free) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                ISSUE: begin
                    r_load_voice <= '0;
                    r_load_note  <= '0;
                    r_load_dur   <= '0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_voice_scheduler;

    localparam int unsigned NV = 3;
    localparam int unsigned NW = 6;
    localparam int unsigned DW = 6;
    localparam int unsigned AW = 8;
    localparam int          AGE_MAX = (1 << AW) - 1;

    logic          clk;
    logic          reset;
    logic          play;
    logic          beat;
    logic [NW-1:0] note_in;
    logic [DW-1:0] duration_in;
    logic          note_valid;
    logic          note_ready;
    logic [NV-1:0] voice_done;
    logic [NV-1:0] load_voice;
    logic [NW-1:0] load_note;
    logic [DW-1:0] load_duration;
    logic [NV-1:0] active_mask;
    logic [1:0]    active_count;

    voice_scheduler #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .DUR_W      (DW),
        .AGE_W      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .play          (play),
        .beat          (beat),
        .note_in       (note_in),
        .duration_in   (duration_in),
        .note_valid    (note_valid),
        .note_ready    (note_ready),
        .voice_done    (voice_done),
        .load_voice    (load_voice),
        .load_note     (load_note),
        .load_duration (load_duration),
        .active_mask   (active_mask),
        .active_count  (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one pending slot, one in-flight load, reservations, pointer, ages.
    bit m_pend, m_issue;
    int m_note, m_dur, m_lv, m_ln, m_ld, m_ptr;
    bit m_res [NV];
    int m_age [NV];

    bit auto_player;
    int p_cnt [NV];
    logic [NV-1:0] load_log [$];
    int            load_cyc [$];
    int            acc_cyc  [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_pend = 0; m_issue = 0; m_ptr = 0;
        m_note = 0; m_dur = 0; m_lv = 0; m_ln = 0; m_ld = 0;
        for (int i = 0; i < NV; i++) begin
            m_res[i] = 0;
            m_age[i] = 0;
        end
    endfunction

    // Applies the scheduling rules to the inputs present before the coming edge.
    function automatic void model_step();
        int grant;
        bit nres [NV];
        grant = -1;
        for (int i = 0; i < NV; i++) nres[i] = m_res[i] && voice_done[i];
        if (m_issue) begin
            m_issue = 0;
        end else if (!m_pend) begin
            if (note_valid) begin
                m_pend = 1;
                m_note = int'(note_in);
                m_dur  = int'(duration_in);
            end
        end else if (play) begin
            if (m_dur == 0) begin
                m_pend = 0;
            end else begin
                for (int k = 0; k < NV; k++) begin
                    int v;
                    v = (m_ptr + k) % NV;
                    if (voice_done[v] && !m_res[v]) begin
                        grant = v;
                        break;
                    end
                end
                if (grant >= 0) m_ptr = (grant + 1) % NV;
`ifdef VOICE_STEAL_EN
                else begin
                    grant = 0;
                    for (int v = 1; v < NV; v++) if (m_age[v] > m_age[grant]) grant = v;
                end
`endif
                if (grant >= 0) begin
                    m_pend  = 0;
                    m_issue = 1;
                    m_lv    = grant;
                    m_ln    = m_note;
                    m_ld    = m_dur;
                    nres[grant] = 1;
                end
            end
        end
`ifdef VOICE_STEAL_EN
        for (int i = 0; i < NV; i++) begin
            if (i == grant) m_age[i] = 0;
            else if (beat && play && (!voice_done[i] || m_res[i]) && m_age[i] < AGE_MAX) m_age[i]++;
        end
`endif
        for (int i = 0; i < NV; i++) m_res[i] = nres[i];
    endfunction

    task automatic compare_all();
        logic [NV-1:0] exp_mask;
        exp_mask = '0;
        for (int i = 0; i < NV; i++) if (!voice_done[i] || m_res[i]) exp_mask[i] = 1'b1;
        check_val("load_voice", load_voice, m_issue ? (32'd1 << m_lv) : 32'd0);
        check_val("load_note", load_note, m_issue ? m_ln : 0);
        check_val("load_duration", load_duration, m_issue ? m_ld : 0);
        check_val("note_ready", note_ready, !m_pend && !m_issue);
        check_val("active_mask", active_mask, exp_mask);
        check_val("active_count", active_count, $countones(exp_mask));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
        if (load_voice != '0) begin
            load_log.push_back(load_voice);
            load_cyc.push_back(cyc);
        end
        if (auto_player) begin
            for (int i = 0; i < NV; i++) begin
                if (load_voice[i]) begin
                    voice_done[i] = 1'b0;
                    p_cnt[i] = 2;
                end else if (p_cnt[i] > 0) begin
                    p_cnt[i]--;
                    if (p_cnt[i] == 0) voice_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input int n, input int d);
        bit acc;
        acc = 0;
        note_in     = NW'(n);
        duration_in = DW'(d);
        note_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            acc = note_ready;
            tick();
            if (acc) break;
        end
        note_valid = 1'b0;
        acc_cyc.push_back(cyc);
        if (!acc) check_val("offer_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < NV; i++) p_cnt[i] = 0;
        @(negedge clk);
        check_val("rst_ready", note_ready, 1);
        check_val("rst_load", load_voice, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; play = 1'b1; beat = 1'b0;
        note_in = '0; duration_in = '0; note_valid = 1'b0;
        voice_done = '1; auto_player = 1;
        do_reset();

        // Reset in the middle of an ISSUE cycle.
        offer(9, 3);
        tick();
        check_val("pre_rst_issue", load_voice, 1);
        #2 reset = 1'b1;
        #1;
        check_val("rst_async_load_voice", load_voice, 0);
        check_val("rst_async_load_note", load_note, 0);
        model_reset();
        voice_done = '1;
        for (int i = 0; i < NV; i++) p_cnt[i] = 0;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_ready_after", note_ready, 1);
        check_val("rst_active_count", active_count, 0);
        ticks(3);

        // Round-robin across four back-to-back notes.
        load_log.delete(); load_cyc.delete(); acc_cyc.delete();
        for (int n = 10; n <= 13; n++) offer(n, 3);
        ticks(3);
        check_val("rr_count", load_log.size(), 4);
        if (load_log.size() == 4) begin
            check_val("rr_v0", load_log[0], 3'b001);
            check_val("rr_v1", load_log[1], 3'b010);
            check_val("rr_v2", load_log[2], 3'b100);
            check_val("rr_v3", load_log[3], 3'b001);
            for (int j = 0; j < 4; j++) check_val("rr_latency", load_cyc[j] - acc_cyc[j], 1);
        end

        // Backpressure with every voice busy.
        auto_player = 0;
        voice_done = '0;
        ticks(2);
        load_log.delete();
        offer(20, 4);
        ticks(6);
        check_val("bp_no_load", load_log.size(), 0);
        check_val("bp_ready", note_ready, 0);
        voice_done = 3'b010;
        tick();
        check_val("bp_voice", load_voice, 3'b010);
        check_val("bp_note", load_note, 20);
        tick();
        voice_done = '0;
        tick();
        voice_done = '1;
        auto_player = 1;
        ticks(2);

        // A rest is swallowed without a load.
        load_log.delete();
        offer(5, 0);
        begin
            int n;
            n = 0;
            while (!note_ready && n < 10) begin
                tick();
                n++;
            end
            check_val("rest_ready_lat", n, 1);
        end
        check_val("rest_no_load", load_log.size(), 0);

        // Pause holds the pending note across beats.
        ticks(4);
        load_log.delete();
        play = 1'b0;
        offer(7, 5);
        beat = 1'b1;
        ticks(10);
        beat = 1'b0;
        check_val("pause_no_load", load_log.size(), 0);
        check_val("pause_ready", note_ready, 0);
        play = 1'b1;
        tick();
        check_val("pause_load", load_voice != '0, 1);
        check_val("pause_note", load_note, 7);
        ticks(4);

        // All voices busy with ages 4, 9, 9.
        auto_player = 0;
        voice_done = '1;
        do_reset();
        offer(1, 9);
        offer(2, 9);
        offer(3, 9);
        ticks(2);
        voice_done = '0;
        tick();
        beat = 1'b1;
        ticks(5);
        beat = 1'b0;
        voice_done = 3'b001;
        offer(4, 9);
        tick();
        voice_done = '0;
        tick();
        beat = 1'b1;
        ticks(4);
        beat = 1'b0;
        load_log.delete();
        offer(30, 7);
        ticks(3);
`ifdef VOICE_STEAL_EN
        check_val("steal_count", load_log.size(), 1);
        if (load_log.size() == 1) check_val("steal_voice", load_log[0], 3'b010);
`else
        check_val("steal_wait_no_load", load_log.size(), 0);
        check_val("steal_wait_ready", note_ready, 0);
`endif
        voice_done = '1;
        ticks(3);

        // Randomized traffic with free-running voice_done.
        for (int t = 0; t < 1500; t++) begin
            play        = ($urandom_range(9) != 0);
            beat        = ($urandom_range(3) == 0);
            note_valid  = 1'($urandom_range(1));
            note_in     = NW'($urandom);
            duration_in = ($urandom_range(7) == 0) ? '0 : DW'($urandom_range(63, 1));
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(5) == 0) voice_done[i] = ~voice_done[i];
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
